// File: rtl/s2p_gearbox_pkg.sv
// s2p_gearbox_pkg: shared types, lane constants and sizing helper for the s2p gearbox (S2P_GEARBOX_FLUSH_EN selects flush)
package s2p_gearbox_pkg;
  typedef enum logic {ST_EMPTY, ST_FILL} state_e;
  localparam int unsigned LANE_NEWEST = 0;
  localparam int unsigned MIN_RATIO = 2;
  function automatic int unsigned cnt_w(input int unsigned ratio);
    return $clog2(ratio + 1);
  endfunction
endpackage

// File: rtl/s2p_lane_buffer.sv
// s2p_lane_buffer: shift register holding the partial word, newest lane at the bottom
module s2p_lane_buffer
  import s2p_gearbox_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LANES  = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_clr,
  input  logic                    i_en,
  input  logic [DATA_W-1:0]       i_data,
  output logic [LANES*DATA_W-1:0] o_buf
);
  localparam int unsigned W = LANES * DATA_W;
  logic [W-1:0] r_buf;
  // each accepted word pushes older lanes toward the MSB end
  always_ff @(posedge clk)
    if (rst || i_clr) r_buf <= '0;
    else if (i_en) r_buf <= (r_buf << DATA_W) | (W'(i_data) << (LANE_NEWEST * DATA_W));
  assign o_buf = r_buf;
endmodule

// File: rtl/s2p_gearbox.sv
// s2p_gearbox: packs RATIO input lanes MSB-first into one wide word; S2P_GEARBOX_FLUSH_EN enables partial-word flush
module s2p_gearbox
  import s2p_gearbox_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RATIO  = 4,
  parameter int unsigned CNT_W  = cnt_w(RATIO)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    flush,
  input  logic [DATA_W-1:0]       i_data,
  input  logic                    i_valid,
  output logic                    i_ready,
  output logic [RATIO*DATA_W-1:0] o_data,
  output logic                    o_valid,
  input  logic                    o_ready,
  output logic [CNT_W-1:0]        o_count
);
  localparam int unsigned OW = RATIO * DATA_W;
  state_e r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [OW-1:0] r_data, w_data_nxt, w_word;
  logic r_valid, w_valid_nxt;
  logic [(RATIO-1)*DATA_W-1:0] w_buf;
  logic w_acc, w_done, w_load;
  assign i_ready = !clear && (!r_valid || o_ready);
  assign w_acc   = i_valid && i_ready;
  assign w_done  = w_acc && (r_cnt == CNT_W'(RATIO - 1));
  s2p_lane_buffer #(.DATA_W(DATA_W), .LANES(RATIO - 1)) u_buf (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (clear),
    .i_en   (w_acc),
    .i_data (i_data),
    .o_buf  (w_buf)
  );
`ifdef S2P_GEARBOX_FLUSH_EN
  logic [CNT_W-1:0] w_lanes, r_count;
  logic [OW-1:0] w_cat;
  assign w_lanes = r_cnt + CNT_W'(w_acc);
  assign w_cat   = w_acc ? {w_buf, i_data} : {{DATA_W{1'b0}}, w_buf};
  assign w_word  = w_cat << ((RATIO - int'(w_lanes)) * DATA_W);
  assign w_load  = w_done || (flush && i_ready && (r_state == ST_FILL || w_acc));
  // lane count of the word currently held in the output register
  always_ff @(posedge clk)
    if (rst || clear) r_count <= '0;
    else if (w_load) r_count <= w_lanes;
  assign o_count = r_count;
`else
  logic w_unused;
  assign w_unused = flush;
  assign w_word   = {w_buf, i_data};
  assign w_load   = w_done;
  assign o_count  = r_valid ? CNT_W'(RATIO) : '0;
`endif
  // fill state, counter and output register next values; clear beats load beats drain
  always_comb begin
    w_cnt_nxt   = (clear || w_load) ? '0 : w_acc ? ((r_state == ST_EMPTY) ? CNT_W'(1) : r_cnt + 1'b1) : r_cnt;
    w_valid_nxt = clear ? 1'b0 : w_load ? 1'b1 : o_ready ? 1'b0 : r_valid;
    w_data_nxt  = clear ? '0 : w_load ? w_word : r_data;
    w_state_nxt = (w_cnt_nxt == '0) ? ST_EMPTY : ST_FILL;
  end
  // state and output registers
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= ST_EMPTY;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_valid <= w_valid_nxt;
      r_data  <= w_data_nxt;
    end
  assign o_data  = r_data;
  assign o_valid = r_valid;
endmodule
